// File: rtl/obsidian_memory_stage_if.sv
// Data-memory port of the Obsidian MEM stage: a registered request held until a
// single-cycle acknowledge (or an abort by the stage).
interface obsidian_memory_stage_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // Handshake: the stage raises mem_req together with mem_we/mem_addr/mem_wdata.
    // It keeps all four stable until the edge where mem_ack=1, or until it aborts.
    // mem_ack is a one-cycle strobe. mem_rdata is sampled on the edge where mem_ack=1.
    // An acknowledge that arrives while no request is outstanding is ignored.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/obsidian_memory_stage.sv
// Obsidian MEM stage: runs loads/stores over a req/ack port, stalls upstream while an
// access is outstanding, and registers the 71-bit MEM_WB bundle.
module obsidian_memory_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [72:0]                     EX_MEM,
    input  logic                            ex_valid,
    output logic                            stall,
    obsidian_memory_stage_if.master         dmem,
    output logic [70:0]                     MEM_WB,
    output logic                            mem_err,
    output logic                            state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    // Hold register: only the fields write-back needs once the access completes.
    logic              h_reg_write;
    logic              h_mem_to_reg;
    logic              h_load;
    logic [31:0]       h_alu;
    logic [4:0]        h_rd;

    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [31:0]       ex_alu;
    logic [31:0]       ex_store_data;
    logic [4:0]        ex_rd;
    logic              ex_memop;
    logic              ex_misaligned;

    assign ex_reg_write  = EX_MEM[72];
    assign ex_mem_to_reg = EX_MEM[71];
    assign ex_mem_read   = EX_MEM[70];
    assign ex_mem_write  = EX_MEM[69];
    assign ex_alu        = EX_MEM[68:37];
    assign ex_store_data = EX_MEM[36:5];
    assign ex_rd         = EX_MEM[4:0];
    assign ex_memop      = ex_mem_read | ex_mem_write;
    assign ex_misaligned = |ex_alu[1:0];

    assign stall          = (state == WAIT);
    assign state_dbg      = (state == WAIT);
    assign dmem.mem_req   = mem_req_r;
    assign dmem.mem_we    = mem_we_r;
    assign dmem.mem_addr  = mem_addr_r;
    assign dmem.mem_wdata = mem_wdata_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            MEM_WB       <= 71'd0;
            mem_err      <= 1'b0;
            h_reg_write  <= 1'b0;
            h_mem_to_reg <= 1'b0;
            h_load       <= 1'b0;
            h_alu        <= 32'd0;
            h_rd         <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ex_valid) begin
                        MEM_WB <= 71'd0;
                    end else if (!ex_memop) begin
                        MEM_WB <= {ex_reg_write, ex_mem_to_reg, 32'd0, ex_alu, ex_rd};
                    end else if (ex_misaligned) begin
                        mem_err <= 1'b1;
                        MEM_WB  <= 71'd0;
                    end else begin
                        // Read+write together behaves as a store, so only a pure read loads.
                        h_reg_write  <= ex_reg_write;
                        h_mem_to_reg <= ex_mem_to_reg;
                        h_load       <= ex_mem_read & ~ex_mem_write;
                        h_alu        <= ex_alu;
                        h_rd         <= ex_rd;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= ex_mem_write;
                        mem_addr_r   <= ex_alu[ADDR_W+1:2];
                        mem_wdata_r  <= ex_store_data;
                        MEM_WB       <= 71'd0;
                        wait_cnt     <= 8'd0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // Ack is tested first so a late ack on the timeout edge still completes.
                    if (dmem.mem_ack) begin
                        MEM_WB    <= {h_reg_write, h_mem_to_reg,
                                      (h_load ? dmem.mem_rdata : 32'd0), h_alu, h_rd};
                        mem_req_r <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req_r <= 1'b0;
                        mem_err   <= 1'b1;
                        MEM_WB    <= 71'd0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        MEM_WB   <= 71'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obsidian_memory_stage.sv
// Directed bench for obsidian_memory_stage: ALU ops, loads, stores, misalignment,
// timeout, and asynchronous reset during an outstanding access.
module tb_obsidian_memory_stage;

    logic        clk;
    logic        rst_n;
    logic [72:0] ex_mem;
    logic        ex_valid;
    logic        stall;
    logic [70:0] mem_wb;
    logic        mem_err;
    logic        state_dbg;

    int errors = 0;
    int checks = 0;

    obsidian_memory_stage_if #(.ADDR_W(10)) mif ();

    obsidian_memory_stage #(.ADDR_W(10), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EX_MEM    (ex_mem),
        .ex_valid  (ex_valid),
        .stall     (stall),
        .dmem      (mif.master),
        .MEM_WB    (mem_wb),
        .mem_err   (mem_err),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] pack_ex(input logic rw, input logic m2r, input logic mr,
                                            input logic mw, input logic [31:0] alu,
                                            input logic [31:0] sd, input logic [4:0] rd);
        return {rw, m2r, mr, mw, alu, sd, rd};
    endfunction

    function automatic logic [70:0] pack_wb(input logic rw, input logic m2r, input logic [31:0] mw,
                                            input logic [31:0] alu, input logic [4:0] rd);
        return {rw, m2r, mw, alu, rd};
    endfunction

    // Driver tasks: inputs change on the falling edge, outputs are checked there too.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [72:0] e);
        ex_valid = v;
        ex_mem   = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_mem        = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_mem        = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        cycle();
        cycle();

        check("rst_mem_wb", 73'(mem_wb), 73'd0);
        check("rst_mem_req", 73'(mif.mem_req), 73'd0);
        check("rst_stall", 73'(stall), 73'd0);
        check("rst_mem_err", 73'(mem_err), 73'd0);
        check("rst_mem_addr", 73'(mif.mem_addr), 73'd0);
        rst_n = 1'b1;
        cycle();
        check("idle_bubble", 73'(mem_wb), 73'd0);

        // 1: ALU op, latency 1
        drive(1'b1, pack_ex(1, 0, 0, 0, 32'h10, 32'h0, 5'd3));
        cycle();
        check("alu_wb", 73'(mem_wb), 73'(pack_wb(1, 0, 32'h0, 32'h10, 5'd3)));
        check("alu_stall", 73'(stall), 73'd0);
        drive(1'b0, '0);
        cycle();
        check("alu_then_bubble", 73'(mem_wb), 73'd0);

        // 2: load, ack two cycles after request, next instruction held by stall
        drive(1'b1, pack_ex(1, 1, 1, 0, 32'h40, 32'h0, 5'd5));
        cycle();
        check("ld_req", 73'(mif.mem_req), 73'd1);
        check("ld_we", 73'(mif.mem_we), 73'd0);
        check("ld_addr", 73'(mif.mem_addr), 73'h010);
        check("ld_stall_c1", 73'(stall), 73'd1);
        check("ld_state_dbg", 73'(state_dbg), 73'd1);
        check("ld_wait_bubble", 73'(mem_wb), 73'd0);
        drive(1'b1, pack_ex(1, 0, 0, 0, 32'h77, 32'h0, 5'd7));
        cycle();
        check("ld_stall_c2", 73'(stall), 73'd1);
        check("ld_req_hold", 73'(mif.mem_req), 73'd1);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        cycle();
        mif.mem_ack   = 1'b0;
        check("ld_wb", 73'(mem_wb), 73'(pack_wb(1, 1, 32'hDEADBEEF, 32'h40, 5'd5)));
        check("ld_stall_done", 73'(stall), 73'd0);
        check("ld_req_done", 73'(mif.mem_req), 73'd0);
        cycle();
        check("ld_next_issue", 73'(mem_wb), 73'(pack_wb(1, 0, 32'h0, 32'h77, 5'd7)));
        drive(1'b0, '0);

        // 3: store with RegWrite=1 writes back with mem word 0
        drive(1'b1, pack_ex(1, 0, 0, 1, 32'h8, 32'h12345678, 5'd2));
        cycle();
        drive(1'b0, '0);
        check("st_we", 73'(mif.mem_we), 73'd1);
        check("st_wdata", 73'(mif.mem_wdata), 73'h12345678);
        check("st_addr", 73'(mif.mem_addr), 73'h002);
        check("st_wait_bubble", 73'(mem_wb), 73'd0);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFF0000;
        cycle();
        mif.mem_ack   = 1'b0;
        check("st_wb", 73'(mem_wb), 73'(pack_wb(1, 0, 32'h0, 32'h8, 5'd2)));

        // Read and write both set: treated as a store
        drive(1'b1, pack_ex(1, 1, 1, 1, 32'hC, 32'hAAAA5555, 5'd9));
        cycle();
        drive(1'b0, '0);
        check("rw_we", 73'(mif.mem_we), 73'd1);
        check("rw_addr", 73'(mif.mem_addr), 73'h003);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'h13572468;
        cycle();
        mif.mem_ack   = 1'b0;
        check("rw_wb", 73'(mem_wb), 73'(pack_wb(1, 1, 32'h0, 32'hC, 5'd9)));

        // Ack while idle is ignored
        mif.mem_ack = 1'b1;
        cycle();
        mif.mem_ack = 1'b0;
        check("idle_ack_req", 73'(mif.mem_req), 73'd0);
        check("idle_ack_wb", 73'(mem_wb), 73'd0);

        // 4: misaligned load
        drive(1'b1, pack_ex(1, 1, 1, 0, 32'h42, 32'h0, 5'd6));
        cycle();
        drive(1'b0, '0);
        check("mis_req", 73'(mif.mem_req), 73'd0);
        check("mis_err", 73'(mem_err), 73'd1);
        check("mis_wb_rw", 73'(mem_wb[70]), 73'd0);
        check("mis_stall", 73'(stall), 73'd0);
        cycle();
        check("mis_err_sticky", 73'(mem_err), 73'd1);

        // 5a: no ack -> abort after 15 request cycles
        do_reset();
        drive(1'b1, pack_ex(1, 1, 1, 0, 32'h100, 32'h0, 5'd4));
        cycle();
        drive(1'b0, '0);
        n = 0;
        while (mif.mem_req && n < 40) begin
            n++;
            cycle();
        end
        check("to_req_cycles", 73'(n), 73'd15);
        check("to_err", 73'(mem_err), 73'd1);
        check("to_wb", 73'(mem_wb), 73'd0);
        check("to_stall", 73'(stall), 73'd0);

        // 5b: ack on the last allowed cycle completes normally
        do_reset();
        drive(1'b1, pack_ex(1, 1, 1, 0, 32'h100, 32'h0, 5'd4));
        cycle();
        drive(1'b0, '0);
        for (int i = 0; i < 14; i++) cycle();
        check("late_req_still", 73'(mif.mem_req), 73'd1);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hCAFEF00D;
        cycle();
        mif.mem_ack   = 1'b0;
        check("late_wb", 73'(mem_wb), 73'(pack_wb(1, 1, 32'hCAFEF00D, 32'h100, 5'd4)));
        check("late_err", 73'(mem_err), 73'd0);

        // 6: async reset mid-WAIT
        drive(1'b1, pack_ex(1, 1, 1, 0, 32'h20, 32'h0, 5'd1));
        cycle();
        drive(1'b0, '0);
        check("ar_req_before", 73'(mif.mem_req), 73'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", 73'(mif.mem_req), 73'd0);
        check("ar_stall", 73'(stall), 73'd0);
        check("ar_wb", 73'(mem_wb), 73'd0);
        check("ar_err", 73'(mem_err), 73'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, pack_ex(1, 0, 0, 0, 32'h55, 32'h0, 5'd11));
        cycle();
        drive(1'b0, '0);
        check("ar_alu_wb", 73'(mem_wb), 73'(pack_wb(1, 0, 32'h0, 32'h55, 5'd11)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
